// File: rtl/det_delay_scan_ctrl.sv
// det_delay_scan_ctrl: sweeps the detector-window delay over a programmed
// range. Each setting is held for a number of sync periods while gated
// detector clicks are counted. One result record is emitted per step.
// Optional feature macro: DET_SCAN_SYNC_TIMEOUT_EN (sync-loss timeout, sets err).
//
// Result handshake: a record transfers on any rising clk edge where
// res_valid & res_ready are both 1. res_valid is a function of state (and the
// abort level) only, never of res_ready. The payload is held stable while
// res_valid=1 and res_ready=0. res_ready may be tied high.
module det_delay_scan_ctrl #(
    parameter int          STEP_W         = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       start_delay,
    input  logic [31:0]       step_delay,
    input  logic [STEP_W-1:0] num_steps,
    input  logic [31:0]       dwell_syncs,
    input  logic              sync_in,
    input  logic              det_gate,
    input  logic              click,
    output logic [31:0]       delay_det,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [STEP_W-1:0] res_step,
    output logic [31:0]       res_delay,
    output logic [31:0]       res_count,
    output logic [2:0]        dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_DWELL  = 3'd3,
        S_REPORT = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t            state_q, state_d;
    logic              sync_cur_q, sync_prev_q;
    logic              click_cur_q, click_prev_q;
    logic [31:0]       cfg_start_q, cfg_start_d;
    logic [31:0]       cfg_step_q, cfg_step_d;
    logic [STEP_W-1:0] cfg_num_q, cfg_num_d;
    logic [31:0]       cfg_dwell_q, cfg_dwell_d;
    logic [STEP_W-1:0] idx_q, idx_d;
    logic [31:0]       delay_q, delay_d;
    logic [31:0]       clicks_q, clicks_d;
    logic [31:0]       syncs_q, syncs_d;

    logic              sync_edge, click_edge;
    logic [31:0]       dwell_eff;
    logic [32:0]       delay_sum;
    logic [31:0]       delay_next;
    logic              last_step;

    // Edge detection works on registered copies of the inputs, so an edge
    // is visible one cycle after the input rises.
    assign sync_edge  = sync_cur_q & ~sync_prev_q;
    assign click_edge = click_cur_q & ~click_prev_q;

    // A dwell of zero sync edges would never end a step; run it as one.
    assign dwell_eff  = (cfg_dwell_q == 32'd0) ? 32'd1 : cfg_dwell_q;

    // Delay increment saturates at all-ones instead of wrapping to a small delay.
    assign delay_sum  = {1'b0, delay_q} + {1'b0, cfg_step_q};
    assign delay_next = delay_sum[32] ? 32'hFFFF_FFFF : delay_sum[31:0];

    assign last_step  = ((idx_q + STEP_W'(1)) == cfg_num_q);

`ifdef DET_SCAN_SYNC_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;
    logic        err_q, err_d;
`endif

    // Next-state and datapath updates; abort overrides everything.
    always_comb begin
        state_d     = state_q;
        cfg_start_d = cfg_start_q;
        cfg_step_d  = cfg_step_q;
        cfg_num_d   = cfg_num_q;
        cfg_dwell_d = cfg_dwell_q;
        idx_d       = idx_q;
        delay_d     = delay_q;
        clicks_d    = clicks_q;
        syncs_d     = syncs_q;
`ifdef DET_SCAN_SYNC_TIMEOUT_EN
        tmo_d       = 32'd0;
        err_d       = err_q;
`endif
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        cfg_start_d = start_delay;
                        cfg_step_d  = step_delay;
                        cfg_num_d   = num_steps;
                        cfg_dwell_d = dwell_syncs;
                        idx_d       = '0;
`ifdef DET_SCAN_SYNC_TIMEOUT_EN
                        err_d       = 1'b0;
`endif
                        state_d     = S_LOAD;
                    end
                end
                S_LOAD: begin
                    delay_d = cfg_start_q;
                    state_d = (cfg_num_q == '0) ? S_DONE : S_SETTLE;
                end
                S_SETTLE: begin
                    // First sync edge under the new delay marks a clean period start.
                    if (sync_edge) begin
                        clicks_d = 32'd0;
                        syncs_d  = 32'd0;
                        state_d  = S_DWELL;
                    end
                end
                S_DWELL: begin
                    if (click_edge && det_gate && (clicks_q != 32'hFFFF_FFFF)) begin
                        clicks_d = clicks_q + 32'd1;
                    end
                    if (sync_edge) begin
                        syncs_d = syncs_q + 32'd1;
                        if ((syncs_q + 32'd1) >= dwell_eff) begin
                            state_d = S_REPORT;
                        end
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        if (last_step) begin
                            state_d = S_DONE;
                        end else begin
                            idx_d   = idx_q + STEP_W'(1);
                            delay_d = delay_next;
                            state_d = S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
`ifdef DET_SCAN_SYNC_TIMEOUT_EN
            // Sync-loss watchdog: restarts on every sync edge while waiting for sync.
            if ((state_q == S_SETTLE) || (state_q == S_DWELL)) begin
                if (sync_edge) begin
                    tmo_d = 32'd0;
                end else if (tmo_q >= (TIMEOUT_CYCLES - 32'd1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + 32'd1;
                end
            end
`endif
        end
    end

    // State, configuration and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            sync_cur_q   <= 1'b0;
            sync_prev_q  <= 1'b0;
            click_cur_q  <= 1'b0;
            click_prev_q <= 1'b0;
            cfg_start_q  <= 32'd0;
            cfg_step_q   <= 32'd0;
            cfg_num_q    <= '0;
            cfg_dwell_q  <= 32'd0;
            idx_q        <= '0;
            delay_q      <= 32'd0;
            clicks_q     <= 32'd0;
            syncs_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            sync_cur_q   <= sync_in;
            sync_prev_q  <= sync_cur_q;
            click_cur_q  <= click;
            click_prev_q <= click_cur_q;
            cfg_start_q  <= cfg_start_d;
            cfg_step_q   <= cfg_step_d;
            cfg_num_q    <= cfg_num_d;
            cfg_dwell_q  <= cfg_dwell_d;
            idx_q        <= idx_d;
            delay_q      <= delay_d;
            clicks_q     <= clicks_d;
            syncs_q      <= syncs_d;
        end
    end

`ifdef DET_SCAN_SYNC_TIMEOUT_EN
    // Timeout counter and sticky error flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_q <= 32'd0;
            err_q <= 1'b0;
        end else begin
            tmo_q <= tmo_d;
            err_q <= err_d;
        end
    end
    assign err = err_q;
`else
    // Without the watchdog there is nothing that can raise err.
    assign err = 1'b0 & (TIMEOUT_CYCLES != 32'd0);
`endif

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE) & ~abort;
    assign res_valid = (state_q == S_REPORT) & ~abort;
    assign res_step  = idx_q;
    assign res_delay = delay_q;
    assign res_count = clicks_q;
    assign delay_det = delay_q;
    assign dbg_state = state_q;

endmodule
